kmkz_fetch: RTL and testbench



---
 rtl/kmkz_defs.sv | 16 +
 rtl/kmkz_fetch_pcgen.sv | 34 +++
 rtl/kmkz_fetch.sv | 81 ++++++++
 tb/tb_kmkz_fetch.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmkz_defs.sv
// Shared Kamikaze-uRV definitions used by the fetch stage.
package kmkz_defs;

   localparam logic [31:0] KMKZ_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] KMKZ_NOP          = 32'h0000_0013;

   typedef enum logic {
      FETCH_BOOT = 1'b0,
      FETCH_RUN  = 1'b1
   } fetch_state_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/kmkz_fetch_pcgen.sv
// Next-PC and instruction-memory address selection for the fetch stage.
module kmkz_fetch_pcgen
   import kmkz_defs::*;
(
   input  logic [31:0] pc_q,
   input  logic        run,
   input  logic        x_bra,
   input  logic [31:0] x_pc_bra,
   input  logic        f_kill,
   input  logic        f_stall,
   input  logic        im_valid,
   output logic [31:0] im_addr,
   output logic [31:0] pc_next
);

   logic [31:0] target;
   logic [31:0] pc_inc;

   assign target = word_align(x_pc_bra);
   assign pc_inc = pc_q + 32'd4;

   // pc_next always equals the address driven this cycle, so pc_q names the
   // single outstanding request on the following cycle.
   always_comb begin
      im_addr = pc_q;
      if (x_bra) begin
         im_addr = target;
      end else if (run && !f_kill && !f_stall && im_valid) begin
         im_addr = pc_inc;
      end
      pc_next = im_addr;
   end

endmodule

// File: rtl/kmkz_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction memory, and
// registers returned instructions for decode.
module kmkz_fetch
   import kmkz_defs::*;
#(
   parameter logic [31:0] RESET_ADDR = KMKZ_RESET_VECTOR
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        f_stall_i,
   input  logic        f_kill_i,
   input  logic        x_bra_i,
   input  logic [31:0] x_pc_bra_i,
   output logic [31:0] im_addr_o,
   output logic        im_rd_o,
   input  logic [31:0] im_data_i,
   input  logic        im_valid_i,
   output logic [31:0] f_ir_o,
   output logic [31:0] f_pc_o,
   output logic        f_valid_o
);

   fetch_state_t state_reg;
   logic [31:0]  pc_reg;
   logic [31:0]  pc_next;
   logic [31:0]  f_ir_reg;
   logic [31:0]  f_pc_reg;
   logic         f_valid_reg;

   kmkz_fetch_pcgen u_pcgen (
      .pc_q     (pc_reg),
      .run      (state_reg == FETCH_RUN),
      .x_bra    (x_bra_i),
      .x_pc_bra (x_pc_bra_i),
      .f_kill   (f_kill_i),
      .f_stall  (f_stall_i),
      .im_valid (im_valid_i),
      .im_addr  (im_addr_o),
      .pc_next  (pc_next)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg   <= FETCH_BOOT;
         pc_reg      <= word_align(RESET_ADDR);
         f_ir_reg    <= KMKZ_NOP;
         f_pc_reg    <= 32'h0000_0000;
         f_valid_reg <= 1'b0;
      end else begin
         pc_reg <= pc_next;
         case (state_reg)
            FETCH_BOOT: begin
               state_reg <= FETCH_RUN;
            end
            FETCH_RUN: begin
               if (x_bra_i || f_kill_i) begin
                  f_valid_reg <= 1'b0;
               end else if (f_stall_i) begin
                  f_valid_reg <= f_valid_reg;
               end else if (im_valid_i) begin
                  f_ir_reg    <= im_data_i;
                  f_pc_reg    <= pc_reg;
                  f_valid_reg <= 1'b1;
               end else begin
                  f_valid_reg <= 1'b0;
               end
            end
            default: begin
               state_reg <= FETCH_BOOT;
            end
         endcase
      end
   end

   // Both states issue a read; only reset silences the strobe.
   assign im_rd_o   = rst_i;
   assign f_ir_o    = f_ir_reg;
   assign f_pc_o    = f_pc_reg;
   assign f_valid_o = f_valid_reg;

endmodule

// File: tb/tb_kmkz_fetch.sv
// Directed bench for kmkz_fetch with a one-cycle-latency memory returning ~addr.
module tb_kmkz_fetch;

   localparam logic [31:0] RST_VEC = 32'h0000_0100;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        f_stall_i;
   logic        f_kill_i;
   logic        x_bra_i;
   logic [31:0] x_pc_bra_i;
   logic [31:0] im_addr_o;
   logic        im_rd_o;
   logic [31:0] im_data_i = 32'h0;
   logic        im_valid_i;
   logic [31:0] f_ir_o;
   logic [31:0] f_pc_o;
   logic        f_valid_o;

   int n_cmp = 0;
   int n_bad = 0;

   kmkz_fetch #(.RESET_ADDR(RST_VEC)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .f_stall_i  (f_stall_i),
      .f_kill_i   (f_kill_i),
      .x_bra_i    (x_bra_i),
      .x_pc_bra_i (x_pc_bra_i),
      .im_addr_o  (im_addr_o),
      .im_rd_o    (im_rd_o),
      .im_data_i  (im_data_i),
      .im_valid_i (im_valid_i),
      .f_ir_o     (f_ir_o),
      .f_pc_o     (f_pc_o),
      .f_valid_o  (f_valid_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) im_data_i <= ~im_addr_o;

   task automatic test_reset();
      n_cmp++;
      if (im_rd_o !== 1'b0 || f_valid_o !== 1'b0 || f_pc_o !== 32'h0 || f_ir_o !== NOP) begin
         n_bad++;
         $display("FAIL reset_state: rd=%b valid=%b pc=%h ir=%h, want 0 0 00000000 %h",
                  im_rd_o, f_valid_o, f_pc_o, f_ir_o, NOP);
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      n_cmp++;
      if (im_addr_o !== RST_VEC || im_rd_o !== 1'b1 || f_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL boot: addr=%h rd=%b valid=%b, want %h 1 0", im_addr_o, im_rd_o, f_valid_o, RST_VEC);
      end
      @(negedge clk_i);
      n_cmp++;
      if (f_valid_o !== 1'b0 || im_addr_o !== RST_VEC + 32'd4) begin
         n_bad++;
         $display("FAIL run1: valid=%b addr=%h, want 0 %h", f_valid_o, im_addr_o, RST_VEC + 32'd4);
      end
      @(negedge clk_i);
      n_cmp++;
      if (f_valid_o !== 1'b1 || f_pc_o !== RST_VEC || f_ir_o !== ~RST_VEC || im_addr_o !== 32'h108) begin
         n_bad++;
         $display("FAIL first_valid: valid=%b pc=%h ir=%h addr=%h, want 1 %h %h 00000108",
                  f_valid_o, f_pc_o, f_ir_o, im_addr_o, RST_VEC, ~RST_VEC);
      end
      $display("txn reset: first fetch pc=%h", f_pc_o);
      @(negedge clk_i);
   endtask

   task automatic test_stall();
      f_stall_i = 1'b1;
      #1;
      n_cmp++;
      if (f_pc_o !== 32'h104 || im_addr_o !== 32'h108) begin
         n_bad++;
         $display("FAIL stall_entry: pc=%h addr=%h, want 00000104 00000108", f_pc_o, im_addr_o);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         n_cmp++;
         if (f_valid_o !== 1'b1 || f_pc_o !== 32'h104 || f_ir_o !== ~32'h104 || im_addr_o !== 32'h108) begin
            n_bad++;
            $display("FAIL stall_hold%0d: valid=%b pc=%h ir=%h addr=%h, want 1 00000104 %h 00000108",
                     i, f_valid_o, f_pc_o, f_ir_o, im_addr_o, ~32'h104);
         end
      end
      f_stall_i = 1'b0;
      #1;
      n_cmp++;
      if (im_addr_o !== 32'h10C) begin
         n_bad++;
         $display("FAIL stall_release_addr: addr=%h, want 0000010c", im_addr_o);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i);
         n_cmp++;
         if (f_valid_o !== 1'b1 || f_pc_o !== 32'h108 + 32'(4 * i) || f_ir_o !== ~(32'h108 + 32'(4 * i))) begin
            n_bad++;
            $display("FAIL stall_resume%0d: valid=%b pc=%h ir=%h, want 1 %h",
                     i, f_valid_o, f_pc_o, f_ir_o, 32'h108 + 32'(4 * i));
         end
      end
      $display("txn stall: resumed at pc=%h", f_pc_o);
   endtask

   task automatic test_kill();
      f_kill_i = 1'b1;
      #1;
      n_cmp++;
      if (im_addr_o !== 32'h110) begin
         n_bad++;
         $display("FAIL kill_addr: addr=%h, want 00000110", im_addr_o);
      end
      @(negedge clk_i);
      f_kill_i = 1'b0;
      n_cmp++;
      if (f_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL kill_valid: valid=%b, want 0", f_valid_o);
      end
      @(negedge clk_i);
      n_cmp++;
      if (f_valid_o !== 1'b1 || f_pc_o !== 32'h110) begin
         n_bad++;
         $display("FAIL kill_refetch: valid=%b pc=%h, want 1 00000110", f_valid_o, f_pc_o);
      end
      $display("txn kill: refetched pc=%h", f_pc_o);
   endtask

   task automatic test_branch_kill();
      x_bra_i = 1'b1;
      x_pc_bra_i = 32'h2003;
      f_kill_i = 1'b1;
      #1;
      n_cmp++;
      if (im_addr_o !== 32'h2000) begin
         n_bad++;
         $display("FAIL bra_addr: addr=%h, want 00002000", im_addr_o);
      end
      @(negedge clk_i);
      x_bra_i = 1'b0;
      f_kill_i = 1'b0;
      #1;
      n_cmp++;
      if (f_valid_o !== 1'b0 || im_addr_o !== 32'h2004) begin
         n_bad++;
         $display("FAIL bra_bubble: valid=%b addr=%h, want 0 00002004", f_valid_o, im_addr_o);
      end
      @(negedge clk_i);
      n_cmp++;
      if (f_valid_o !== 1'b1 || f_pc_o !== 32'h2000 || f_ir_o !== ~32'h2000) begin
         n_bad++;
         $display("FAIL bra_target: valid=%b pc=%h ir=%h, want 1 00002000 %h", f_valid_o, f_pc_o, f_ir_o, ~32'h2000);
      end
      $display("txn branch: target pc=%h", f_pc_o);
   endtask

   task automatic test_wait();
      im_valid_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_cmp++;
         if (im_addr_o !== 32'h2004) begin
            n_bad++;
            $display("FAIL wait_addr%0d: addr=%h, want 00002004", i, im_addr_o);
         end
         @(negedge clk_i);
         n_cmp++;
         if (f_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_bubble%0d: valid=%b, want 0", i, f_valid_o);
         end
      end
      im_valid_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i);
         n_cmp++;
         if (f_valid_o !== 1'b1 || f_pc_o !== 32'h2004 + 32'(4 * i) || f_ir_o !== ~(32'h2004 + 32'(4 * i))) begin
            n_bad++;
            $display("FAIL wait_resume%0d: valid=%b pc=%h ir=%h, want 1 %h",
                     i, f_valid_o, f_pc_o, f_ir_o, 32'h2004 + 32'(4 * i));
         end
      end
      $display("txn wait: resumed at pc=%h", f_pc_o);
   endtask

   task automatic test_bra_stall_wait();
      f_stall_i = 1'b1;
      im_valid_i = 1'b0;
      x_bra_i = 1'b1;
      x_pc_bra_i = 32'h3000;
      #1;
      n_cmp++;
      if (im_addr_o !== 32'h3000) begin
         n_bad++;
         $display("FAIL bsw_addr: addr=%h, want 00003000", im_addr_o);
      end
      @(negedge clk_i);
      f_stall_i = 1'b0;
      im_valid_i = 1'b1;
      x_bra_i = 1'b0;
      #1;
      n_cmp++;
      if (f_valid_o !== 1'b0 || im_addr_o !== 32'h3004) begin
         n_bad++;
         $display("FAIL bsw_redirect: valid=%b addr=%h, want 0 00003004", f_valid_o, im_addr_o);
      end
      @(negedge clk_i);
      n_cmp++;
      if (f_valid_o !== 1'b1 || f_pc_o !== 32'h3000) begin
         n_bad++;
         $display("FAIL bsw_target: valid=%b pc=%h, want 1 00003000", f_valid_o, f_pc_o);
      end
      $display("txn bra_stall_wait: target pc=%h", f_pc_o);
   endtask

   task automatic test_wrap();
      x_bra_i = 1'b1;
      x_pc_bra_i = 32'hFFFF_FFFE;
      #1;
      n_cmp++;
      if (im_addr_o !== 32'hFFFF_FFFC) begin
         n_bad++;
         $display("FAIL wrap_bra: addr=%h, want fffffffc", im_addr_o);
      end
      @(negedge clk_i);
      x_bra_i = 1'b0;
      #1;
      n_cmp++;
      if (im_addr_o !== 32'h0) begin
         n_bad++;
         $display("FAIL wrap_addr: addr=%h, want 00000000", im_addr_o);
      end
      @(negedge clk_i);
      #1;
      n_cmp++;
      if (f_valid_o !== 1'b1 || f_pc_o !== 32'hFFFF_FFFC || im_addr_o !== 32'h4) begin
         n_bad++;
         $display("FAIL wrap_out: valid=%b pc=%h addr=%h, want 1 fffffffc 00000004", f_valid_o, f_pc_o, im_addr_o);
      end
      $display("txn wrap: pc=%h next addr=%h", f_pc_o, im_addr_o);
   endtask

   task automatic test_async_reset();
      #2;
      rst_i = 1'b0;
      #1;
      n_cmp++;
      if (f_valid_o !== 1'b0 || f_pc_o !== 32'h0 || f_ir_o !== NOP || im_rd_o !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset: valid=%b pc=%h ir=%h rd=%b, want 0 00000000 %h 0",
                  f_valid_o, f_pc_o, f_ir_o, im_rd_o, NOP);
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      n_cmp++;
      if (im_addr_o !== RST_VEC || im_rd_o !== 1'b1) begin
         n_bad++;
         $display("FAIL reboot_addr: addr=%h rd=%b, want %h 1", im_addr_o, im_rd_o, RST_VEC);
      end
      @(negedge clk_i);
      @(negedge clk_i);
      n_cmp++;
      if (f_valid_o !== 1'b1 || f_pc_o !== RST_VEC) begin
         n_bad++;
         $display("FAIL reboot_first: valid=%b pc=%h, want 1 %h", f_valid_o, f_pc_o, RST_VEC);
      end
      $display("txn async_reset: restarted at pc=%h", f_pc_o);
   endtask

   initial begin
      rst_i = 1'b0;
      f_stall_i = 1'b0;
      f_kill_i = 1'b0;
      x_bra_i = 1'b0;
      x_pc_bra_i = 32'h0;
      im_valid_i = 1'b1;
      #12;
      test_reset();
      test_stall();
      test_kill();
      test_branch_kill();
      test_wait();
      test_bra_stall_wait();
      test_wrap();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
